// File: rtl/wb_pkg.sv
// Shared types for the writeback retirement buffer: entry control flags, FSM state
// and width helpers derived from the buffer/channel parameters.
package wb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_t;

    // Wide payload fields (pc, dest, data, xcpt_addr) are parameter-sized, so they
    // live in separate arrays alongside these per-entry flags.
    typedef struct packed {
        logic valid;
        logic done;
        logic write_rf;
        logic xcpt;
    } rob_entry_t;

    function automatic int tag_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/wb_cmp_select.sv
// Completion matcher for one buffer entry: reports whether any channel targets
// this entry and, if several do, selects the lowest-indexed one.
module wb_cmp_select
    import wb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 3,
    parameter int ENTRY  = 0,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0]       cmp_valid,
    input  logic [NUM_CH*TAG_W-1:0] cmp_tag,
    output logic                    hit,
    output logic [CH_W-1:0]         ch
);

    localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(ENTRY);

    // Scan from the highest index down so the lowest matching channel is written last.
    always_comb begin
        hit = 1'b0;
        ch  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (cmp_valid[c] && (cmp_tag[c*TAG_W +: TAG_W] == MY_TAG)) begin
                hit = 1'b1;
                ch  = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/wb_retire_buffer.sv
// In-order retirement buffer: gathers out-of-order completions from NUM_CH channels,
// retires one entry per cycle to the RF and reports precise exceptions with a flush.
module wb_retire_buffer
    import wb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32,
    parameter int TAG_W  = tag_w(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alloc_valid,
    input  logic [PC_W-1:0]          alloc_pc,
    output logic                     alloc_ready,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [NUM_CH-1:0]        cmp_valid,
    input  logic [NUM_CH*TAG_W-1:0]  cmp_tag,
    input  logic [NUM_CH-1:0]        cmp_write_rf,
    input  logic [NUM_CH*ADDR_W-1:0] cmp_dest,
    input  logic [NUM_CH*DATA_W-1:0] cmp_data,
    input  logic [NUM_CH-1:0]        cmp_xcpt,
    input  logic [NUM_CH*PC_W-1:0]   cmp_xcpt_addr,
    output logic                     req_to_RF_writeEn,
    output logic [ADDR_W-1:0]        req_to_RF_dest,
    output logic [DATA_W-1:0]        req_to_RF_data,
    output logic                     xcpt_valid,
    output logic [PC_W-1:0]          rmPC,
    output logic [PC_W-1:0]          rmAddr,
    output logic                     flush,
    output logic [TAG_W:0]           occupancy
);

    localparam int               CH_W    = ch_w(NUM_CH);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]   CNT_MAX = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

    wb_state_t         state;
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;
    rob_entry_t        ent     [DEPTH];
    logic [PC_W-1:0]   pc_q    [DEPTH];
    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PC_W-1:0]   xaddr_q [DEPTH];

    logic [DEPTH-1:0]  hit;
    logic [DEPTH-1:0]  accept;
    logic [CH_W-1:0]   sel     [DEPTH];
    logic              do_alloc;
    logic              retire;
    logic              retire_xcpt;

    assign alloc_ready = (state == RUN) && (count < CNT_MAX);
    assign alloc_tag   = tail;
    assign occupancy   = count;
    assign do_alloc    = alloc_valid && alloc_ready;
    assign retire      = (state == RUN) && ent[head].valid && ent[head].done;
    assign retire_xcpt = retire && ent[head].xcpt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_sel
        wb_cmp_select #(
            .NUM_CH (NUM_CH),
            .TAG_W  (TAG_W),
            .ENTRY  (i)
        ) u_sel (
            .cmp_valid (cmp_valid),
            .cmp_tag   (cmp_tag),
            .hit       (hit[i]),
            .ch        (sel[i])
        );
        // An entry being allocated this cycle is still invalid, so it never accepts.
        assign accept[i] = hit[i] && ent[i].valid && !ent[i].done && (state == RUN);
    end

    // Control and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= RUN;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            req_to_RF_writeEn <= 1'b0;
            req_to_RF_dest    <= '0;
            req_to_RF_data    <= '0;
            xcpt_valid        <= 1'b0;
            flush             <= 1'b0;
            rmPC              <= '0;
            rmAddr            <= '0;
        end else begin
            req_to_RF_writeEn <= 1'b0;
            xcpt_valid        <= 1'b0;
            flush             <= 1'b0;
            if (state == RUN) begin
                if (retire_xcpt) begin
                    state      <= FLUSH;
                    xcpt_valid <= 1'b1;
                    flush      <= 1'b1;
                    rmPC       <= pc_q[head];
                    rmAddr     <= xaddr_q[head];
                    head       <= '0;
                    tail       <= '0;
                    count      <= '0;
                    for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (accept[i]) begin
                            ent[i].done     <= 1'b1;
                            ent[i].write_rf <= cmp_write_rf[sel[i]];
                            ent[i].xcpt     <= cmp_xcpt[sel[i]];
                        end
                    end
                    if (retire) begin
                        ent[head]         <= '0;
                        head              <= head + TAG_ONE;
                        req_to_RF_writeEn <= ent[head].write_rf;
                        req_to_RF_dest    <= dest_q[head];
                        req_to_RF_data    <= data_q[head];
                    end
                    if (do_alloc) begin
                        ent[tail].valid <= 1'b1;
                        ent[tail].done  <= 1'b0;
                        tail            <= tail + TAG_ONE;
                    end
                    if (do_alloc && !retire)
                        count <= count + CNT_ONE;
                    else if (retire && !do_alloc)
                        count <= count - CNT_ONE;
                end
            end else begin
                state <= RUN;
            end
        end
    end

    // Entry payload storage
    always_ff @(posedge clock) begin
        if (do_alloc) pc_q[tail] <= alloc_pc;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept[i]) begin
                dest_q[i]  <= cmp_dest[sel[i]*ADDR_W +: ADDR_W];
                data_q[i]  <= cmp_data[sel[i]*DATA_W +: DATA_W];
                xaddr_q[i] <= cmp_xcpt_addr[sel[i]*PC_W +: PC_W];
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed bench for wb_retire_buffer with default parameters (2 channels, 8 entries).
module tb_wb_retire_buffer;

    logic        clock;
    logic        reset;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic [1:0]  cmp_valid;
    logic [5:0]  cmp_tag;
    logic [1:0]  cmp_write_rf;
    logic [9:0]  cmp_dest;
    logic [63:0] cmp_data;
    logic [1:0]  cmp_xcpt;
    logic [63:0] cmp_xcpt_addr;
    logic        req_to_RF_writeEn;
    logic [4:0]  req_to_RF_dest;
    logic [31:0] req_to_RF_data;
    logic        xcpt_valid;
    logic [31:0] rmPC;
    logic [31:0] rmAddr;
    logic        flush;
    logic [3:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_retire_buffer dut (
        .clock             (clock),
        .reset             (reset),
        .alloc_valid       (alloc_valid),
        .alloc_pc          (alloc_pc),
        .alloc_ready       (alloc_ready),
        .alloc_tag         (alloc_tag),
        .cmp_valid         (cmp_valid),
        .cmp_tag           (cmp_tag),
        .cmp_write_rf      (cmp_write_rf),
        .cmp_dest          (cmp_dest),
        .cmp_data          (cmp_data),
        .cmp_xcpt          (cmp_xcpt),
        .cmp_xcpt_addr     (cmp_xcpt_addr),
        .req_to_RF_writeEn (req_to_RF_writeEn),
        .req_to_RF_dest    (req_to_RF_dest),
        .req_to_RF_data    (req_to_RF_data),
        .xcpt_valid        (xcpt_valid),
        .rmPC              (rmPC),
        .rmAddr            (rmAddr),
        .flush             (flush),
        .occupancy         (occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_cmp();
        cmp_valid     = '0;
        cmp_tag       = '0;
        cmp_write_rf  = '0;
        cmp_dest      = '0;
        cmp_data      = '0;
        cmp_xcpt      = '0;
        cmp_xcpt_addr = '0;
    endtask

    task automatic set_cmp(input int c, input logic [2:0] tag, input logic wr,
                           input logic [4:0] dest, input logic [31:0] data,
                           input logic x, input logic [31:0] xa);
        cmp_valid[c]               = 1'b1;
        cmp_tag[c*3 +: 3]          = tag;
        cmp_write_rf[c]            = wr;
        cmp_dest[c*5 +: 5]         = dest;
        cmp_data[c*32 +: 32]       = data;
        cmp_xcpt[c]                = x;
        cmp_xcpt_addr[c*32 +: 32]  = xa;
    endtask

    task automatic do_reset();
        alloc_valid = 1'b0;
        alloc_pc    = '0;
        clear_cmp();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic alloc_n(input int n, input logic [31:0] pc0);
        alloc_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            alloc_pc = pc0 + 32'(4 * i);
            step();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        alloc_valid = 1'b0;
        alloc_pc    = '0;
        clear_cmp();
        #3;
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_rf got en=%0b dest=%0d data=%0h want 0/0/0", req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data);
        end
        n_tests++;
        if ({xcpt_valid, flush, rmPC, rmAddr} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_xcpt got xv=%0b fl=%0b pc=%0h addr=%0h want all 0", xcpt_valid, flush, rmPC, rmAddr);
        end
        n_tests++;
        if ({alloc_ready, alloc_tag, occupancy} !== {1'b1, 3'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_alloc got rdy=%0b tag=%0d occ=%0d want 1/0/0", alloc_ready, alloc_tag, occupancy);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_out_of_order();
        do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_pc = 32'h40 + 32'(4 * i);
            n_tests++;
            if (alloc_tag !== 3'(i)) begin
                n_fail++;
                $display("FAIL ooo_tag%0d got %0d want %0d", i, alloc_tag, i);
            end
            step();
        end
        alloc_valid = 1'b0;
        n_tests++;
        if (occupancy !== 4'd3) begin
            n_fail++;
            $display("FAIL ooo_occ3 got %0d want 3", occupancy);
        end
        set_cmp(0, 3'd2, 1'b1, 5'd3, 32'hA, 1'b0, 32'h0);
        step();
        clear_cmp();
        set_cmp(0, 3'd0, 1'b1, 5'd4, 32'hB, 1'b0, 32'h0);
        step();
        n_tests++;
        if (req_to_RF_writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL ooo_early_wr got %0b want 0", req_to_RF_writeEn);
        end
        clear_cmp();
        set_cmp(0, 3'd1, 1'b1, 5'd5, 32'hC, 1'b0, 32'h0);
        step();
        clear_cmp();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data} !== {1'b1, 5'd4, 32'hB}) begin
            n_fail++;
            $display("FAIL ooo_wr0 got en=%0b dest=%0d data=%0h want 1/4/b", req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data);
        end
        step();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data} !== {1'b1, 5'd5, 32'hC}) begin
            n_fail++;
            $display("FAIL ooo_wr1 got en=%0b dest=%0d data=%0h want 1/5/c", req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data);
        end
        step();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data} !== {1'b1, 5'd3, 32'hA}) begin
            n_fail++;
            $display("FAIL ooo_wr2 got en=%0b dest=%0d data=%0h want 1/3/a", req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data);
        end
        step();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, occupancy} !== {1'b0, 5'd3, 4'd0}) begin
            n_fail++;
            $display("FAIL ooo_idle got en=%0b dest=%0d occ=%0d want 0/3/0", req_to_RF_writeEn, req_to_RF_dest, occupancy);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        alloc_n(8, 32'h300);
        n_tests++;
        if ({alloc_ready, occupancy, alloc_tag} !== {1'b0, 4'd8, 3'd0}) begin
            n_fail++;
            $display("FAIL full_state got rdy=%0b occ=%0d tag=%0d want 0/8/0", alloc_ready, occupancy, alloc_tag);
        end
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        n_tests++;
        if (occupancy !== 4'd8) begin
            n_fail++;
            $display("FAIL full_no_overalloc got occ=%0d want 8", occupancy);
        end
        set_cmp(0, 3'd0, 1'b1, 5'd7, 32'h77, 1'b0, 32'h0);
        step();
        clear_cmp();
        n_tests++;
        if (alloc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_before_retire got rdy=%0b want 0", alloc_ready);
        end
        step();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, occupancy, alloc_ready, alloc_tag}
                !== {1'b1, 5'd7, 32'h77, 4'd7, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL full_retire got en=%0b dest=%0d data=%0h occ=%0d rdy=%0b tag=%0d want 1/7/77/7/1/0",
                     req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, occupancy, alloc_ready, alloc_tag);
        end
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        n_tests++;
        if ({occupancy, alloc_tag, alloc_ready} !== {4'd8, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL full_wrap_alloc got occ=%0d tag=%0d rdy=%0b want 8/1/0", occupancy, alloc_tag, alloc_ready);
        end
    endtask

    task automatic test_exception();
        do_reset();
        alloc_n(3, 32'hFC);
        set_cmp(0, 3'd0, 1'b1, 5'd2, 32'h55, 1'b0, 32'h0);
        set_cmp(1, 3'd1, 1'b1, 5'd9, 32'h99, 1'b1, 32'h2000);
        step();
        clear_cmp();
        step();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, xcpt_valid} !== {1'b1, 5'd2, 32'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL xc_clean_wr got en=%0b dest=%0d data=%0h xv=%0b want 1/2/55/0",
                     req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, xcpt_valid);
        end
        step();
        n_tests++;
        if ({xcpt_valid, flush, rmPC, rmAddr} !== {1'b1, 1'b1, 32'h100, 32'h2000}) begin
            n_fail++;
            $display("FAIL xc_pulse got xv=%0b fl=%0b pc=%0h addr=%0h want 1/1/100/2000", xcpt_valid, flush, rmPC, rmAddr);
        end
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, occupancy, alloc_ready} !== {1'b0, 5'd2, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL xc_flush_state got en=%0b dest=%0d occ=%0d rdy=%0b want 0/2/0/0",
                     req_to_RF_writeEn, req_to_RF_dest, occupancy, alloc_ready);
        end
        set_cmp(0, 3'd2, 1'b1, 5'd3, 32'hEE, 1'b0, 32'h0);
        step();
        n_tests++;
        if ({xcpt_valid, flush, rmPC, rmAddr, alloc_ready, alloc_tag} !== {1'b0, 1'b0, 32'h100, 32'h2000, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL xc_after got xv=%0b fl=%0b pc=%0h addr=%0h rdy=%0b tag=%0d want 0/0/100/2000/1/0",
                     xcpt_valid, flush, rmPC, rmAddr, alloc_ready, alloc_tag);
        end
        step();
        clear_cmp();
        step();
        n_tests++;
        if ({req_to_RF_writeEn, occupancy} !== {1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL xc_stale_cmp got en=%0b occ=%0d want 0/0", req_to_RF_writeEn, occupancy);
        end
    endtask

    task automatic test_same_tag();
        do_reset();
        alloc_n(4, 32'h500);
        set_cmp(0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        set_cmp(1, 3'd1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        step();
        clear_cmp();
        set_cmp(0, 3'd2, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        step();
        clear_cmp();
        n_tests++;
        if ({req_to_RF_writeEn, occupancy} !== {1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL same_nowr_retire got en=%0b occ=%0d want 0/3", req_to_RF_writeEn, occupancy);
        end
        set_cmp(0, 3'd3, 1'b1, 5'd6, 32'h11, 1'b0, 32'h0);
        set_cmp(1, 3'd3, 1'b1, 5'd7, 32'h22, 1'b0, 32'h0);
        step();
        clear_cmp();
        set_cmp(1, 3'd3, 1'b1, 5'd8, 32'h33, 1'b0, 32'h0);
        step();
        clear_cmp();
        n_tests++;
        if ({req_to_RF_writeEn, occupancy} !== {1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL same_pre got en=%0b occ=%0d want 0/1", req_to_RF_writeEn, occupancy);
        end
        step();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data} !== {1'b1, 5'd6, 32'h11}) begin
            n_fail++;
            $display("FAIL same_tag_win got en=%0b dest=%0d data=%0h want 1/6/11", req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data);
        end
        step();
        n_tests++;
        if ({req_to_RF_writeEn, occupancy} !== {1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL same_tag_end got en=%0b occ=%0d want 0/0", req_to_RF_writeEn, occupancy);
        end
    endtask

    task automatic test_bad_tag();
        do_reset();
        alloc_n(2, 32'h600);
        set_cmp(0, 3'd5, 1'b1, 5'd1, 32'hDEAD, 1'b0, 32'h0);
        step();
        clear_cmp();
        step();
        step();
        n_tests++;
        if ({req_to_RF_writeEn, occupancy} !== {1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL bad_tag got en=%0b occ=%0d want 0/2", req_to_RF_writeEn, occupancy);
        end
        set_cmp(1, 3'd0, 1'b1, 5'd8, 32'h80, 1'b0, 32'h0);
        step();
        clear_cmp();
        step();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, occupancy} !== {1'b1, 5'd8, 32'h80, 4'd1}) begin
            n_fail++;
            $display("FAIL bad_tag_after got en=%0b dest=%0d data=%0h occ=%0d want 1/8/80/1",
                     req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, occupancy);
        end
    endtask

    task automatic test_reset_mid();
        int writes;
        do_reset();
        alloc_n(4, 32'h700);
        set_cmp(0, 3'd0, 1'b1, 5'd10, 32'hA0, 1'b0, 32'h0);
        set_cmp(1, 3'd1, 1'b1, 5'd11, 32'hA1, 1'b0, 32'h0);
        step();
        clear_cmp();
        set_cmp(0, 3'd2, 1'b1, 5'd12, 32'hA2, 1'b0, 32'h0);
        set_cmp(1, 3'd3, 1'b1, 5'd13, 32'hA3, 1'b1, 32'h3000);
        step();
        clear_cmp();
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data} !== {1'b1, 5'd10, 32'hA0}) begin
            n_fail++;
            $display("FAIL mid_pre got en=%0b dest=%0d data=%0h want 1/10/a0", req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, occupancy, alloc_tag, alloc_ready}
                !== {1'b0, 5'd0, 32'h0, 4'd0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_async got en=%0b dest=%0d data=%0h occ=%0d tag=%0d rdy=%0b want 0/0/0/0/0/1",
                     req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, occupancy, alloc_tag, alloc_ready);
        end
        step();
        step();
        reset = 1'b1;
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (req_to_RF_writeEn === 1'b1 || xcpt_valid === 1'b1) writes++;
        end
        n_tests++;
        if ({writes, occupancy, alloc_tag} !== {32'd0, 4'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL mid_after got events=%0d occ=%0d tag=%0d want 0/0/0", writes, occupancy, alloc_tag);
        end
    endtask

    initial begin
        test_reset();
        test_out_of_order();
        test_full_wrap();
        test_exception();
        test_same_tag();
        test_bad_tag();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
